// File: rtl/pulp_dma_sched_pkg.sv
// Shared types and cluster-level defaults for the DMA burst scheduler.
// Struct field widths follow the cluster configuration below.
package pulp_dma_sched_pkg;

   localparam int unsigned N_CORES            = 8;
   localparam int unsigned AXI_AW             = 64;
   localparam int unsigned AXI_DW             = 64;
   localparam int unsigned LEN_W              = 32;
   localparam int unsigned DMA_MAX_BURST_SIZE = 2048;
   localparam int unsigned DMA_MAX_N_TXNS     = 8;
   localparam int unsigned PAGE_SIZE          = 4096;
   localparam int unsigned BPB                = AXI_DW / 8;
   localparam int unsigned ID_W               = $clog2(N_CORES);

   typedef struct packed {
      logic [AXI_AW-1:0] addr;
      logic [LEN_W-1:0]  len;
      logic [ID_W-1:0]   id;
   } job_t;

   typedef struct packed {
      logic [AXI_AW-1:0] addr;
      logic [7:0]        len;
      logic [ID_W-1:0]   id;
   } burst_t;

   // Unsigned minimum on byte counts.
   function automatic logic [LEN_W-1:0] umin(input logic [LEN_W-1:0] a,
                                             input logic [LEN_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/pulp_dma_rr_arb.sv
// Round-robin arbiter: combinational grant of the first valid requester at or
// after the pointer; the pointer moves past the winner on every grant.
module pulp_dma_rr_arb #(
   parameter int unsigned N  = 8,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [N-1:0]  valid_i,
   input  logic          en_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] gnt_idx_o,
   output logic          gnt_valid_o
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] k;

   // Scan from the pointer; N is a power of two so the index wraps for free.
   always_comb begin
      gnt_o       = '0;
      gnt_idx_o   = '0;
      gnt_valid_o = 1'b0;
      k           = '0;
      if (en_i) begin
         for (int i = 0; i < int'(N); i++) begin
            k = ptr_q + IW'(i);
            if (!gnt_valid_o && valid_i[k]) begin
               gnt_valid_o = 1'b1;
               gnt_idx_o   = k;
            end
         end
      end
      if (gnt_valid_o) gnt_o[gnt_idx_o] = 1'b1;
   end

   // Pointer advances to the slot after the winner.
   always_ff @(posedge clk_i) begin
      if (!rst_ni)          ptr_q <= '0;
      else if (gnt_valid_o) ptr_q <= gnt_idx_o + IW'(1);
   end

endmodule

// File: rtl/pulp_dma_burst_sched.sv
// DMA front-end scheduler: round-robin job intake, split into AXI read bursts
// (<= MAX_BURST_SIZE, never crossing a 4 KiB page), at most MAX_TXNS in flight.
// Optional performance counters: define PULP_DMA_SCHED_PERF_EN.
module pulp_dma_burst_sched
   import pulp_dma_sched_pkg::*;
#(
   parameter int unsigned N_REQ          = pulp_dma_sched_pkg::N_CORES,
   parameter int unsigned AXI_AW         = pulp_dma_sched_pkg::AXI_AW,
   parameter int unsigned AXI_DW         = pulp_dma_sched_pkg::AXI_DW,
   parameter int unsigned LEN_W          = pulp_dma_sched_pkg::LEN_W,
   parameter int unsigned MAX_BURST_SIZE = pulp_dma_sched_pkg::DMA_MAX_BURST_SIZE,
   parameter int unsigned MAX_TXNS       = pulp_dma_sched_pkg::DMA_MAX_N_TXNS,
   localparam int unsigned IW            = $clog2(N_REQ)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [N_REQ-1:0]        req_valid_i,
   output logic [N_REQ-1:0]        req_ready_o,
   input  logic [N_REQ*AXI_AW-1:0] req_addr_i,
   input  logic [N_REQ*LEN_W-1:0]  req_len_i,
   output logic                    burst_valid_o,
   input  logic                    burst_ready_i,
   output logic [AXI_AW-1:0]       burst_addr_o,
   output logic [7:0]              burst_len_o,
   output logic [IW-1:0]           burst_id_o,
   input  logic                    cpl_valid_i,
   output logic                    done_valid_o,
   output logic [IW-1:0]           done_id_o,
   output logic                    busy_o
`ifdef PULP_DMA_SCHED_PERF_EN
   ,
   output logic [31:0]             perf_bursts_o,
   output logic [31:0]             perf_stall_o
`endif
);

   localparam int unsigned BYTES_PB = AXI_DW / 8;
   localparam int unsigned OFF      = $clog2(BYTES_PB);
   localparam int unsigned CW       = $clog2(MAX_TXNS + 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_ISSUE = 1'b1;

   logic [N_REQ-1:0][AXI_AW-1:0] addr_arr;
   logic [N_REQ-1:0][LEN_W-1:0]  len_arr;
   assign addr_arr = req_addr_i;
   assign len_arr  = req_len_i;

   logic [0:0]       state_q, state_d;
   job_t             job_q, job_d;
   logic [CW-1:0]    out_q, out_d;
   logic             done_q, done_d;
   logic [IW-1:0]    done_id_q, done_id_d;

   logic [N_REQ-1:0] gnt;
   logic [IW-1:0]    gnt_idx;
   logic             gnt_any;
   logic             issue, full, hs;
   logic [12:0]      page_rem;
   logic [LEN_W-1:0] bytes;
   burst_t           bst;

   pulp_dma_rr_arb #(.N(N_REQ)) i_arb (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .valid_i     (req_valid_i),
      .en_i        (state_q == S_IDLE),
      .gnt_o       (gnt),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_any)
   );

   assign req_ready_o = gnt;

   // Burst size: remaining bytes clipped by the burst cap and the page end.
   assign page_rem = 13'(PAGE_SIZE) - {1'b0, job_q.addr[11:0]};
   assign bytes    = umin(umin(job_q.len, LEN_W'(MAX_BURST_SIZE)), LEN_W'(page_rem));

   assign issue         = (state_q == S_ISSUE);
   assign full          = (out_q == CW'(MAX_TXNS));
   assign burst_valid_o = issue && !full;
   assign hs            = burst_valid_o && burst_ready_i;

   // Descriptor comes straight from job registers, so it holds while stalled.
   always_comb begin
      bst.addr = job_q.addr;
      bst.len  = 8'((bytes >> OFF) - LEN_W'(1));
      bst.id   = job_q.id;
   end

   assign burst_addr_o = issue ? bst.addr : '0;
   assign burst_len_o  = issue ? bst.len  : '0;
   assign burst_id_o   = issue ? bst.id   : '0;
   assign done_valid_o = done_q;
   assign done_id_o    = done_id_q;
   assign busy_o       = issue || (out_q != '0);

   // Job intake in IDLE, burst-by-burst consumption in ISSUE.
   always_comb begin
      state_d   = state_q;
      job_d     = job_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_any) begin
               job_d.addr = addr_arr[gnt_idx] & ~AXI_AW'(BYTES_PB - 1);
               job_d.len  = len_arr[gnt_idx]  & ~LEN_W'(BYTES_PB - 1);
               job_d.id   = gnt_idx;
               if (job_d.len == '0) begin
                  done_d    = 1'b1;
                  done_id_d = gnt_idx;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         default: begin
            if (hs) begin
               job_d.addr = job_q.addr + AXI_AW'(bytes);
               job_d.len  = job_q.len - bytes;
               if (job_d.len == '0) begin
                  state_d   = S_IDLE;
                  done_d    = 1'b1;
                  done_id_d = job_q.id;
               end
            end
         end
      endcase
   end

   // Outstanding bursts: issue adds, completion subtracts, floor at zero.
   always_comb begin
      out_d = out_q;
      if (hs && !cpl_valid_i)                         out_d = out_q + CW'(1);
      else if (!hs && cpl_valid_i && (out_q != '0))   out_d = out_q - CW'(1);
   end

   // State registers; reset drops any job and all in-flight accounting.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         job_q     <= '0;
         out_q     <= '0;
         done_q    <= 1'b0;
         done_id_q <= '0;
      end else begin
         state_q   <= state_d;
         job_q     <= job_d;
         out_q     <= out_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
      end
   end

`ifdef PULP_DMA_SCHED_PERF_EN
   logic [31:0] perf_bursts_q, perf_stall_q;

   // Wrapping event counters: accepted bursts and cycles stalled on a full window.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         perf_bursts_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         if (hs)            perf_bursts_q <= perf_bursts_q + 32'd1;
         if (issue && full) perf_stall_q  <= perf_stall_q + 32'd1;
      end
   end

   assign perf_bursts_o = perf_bursts_q;
   assign perf_stall_o  = perf_stall_q;
`endif

`ifndef SYNTHESIS
   cpl_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   cpl_valid_i |-> (out_q != '0));
`endif

endmodule
